muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer beside the EXE-stage ALU; owns the HI/LO registers for MULT/MULTU/DIV/DIVU.
- Accepts one operation from EXE and runs a shift-add multiply or restoring divide over WIDTH cycles.
- Asserts a stall to the pipeline control unit until HI/LO are valid.

---
 rtl/muldiv_seq_if.sv | 42 ++++
 rtl/muldiv_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/result bundle between the EXE stage and the
// iterative multiply/divide sequencer.
//
// Handshake: start is a single-cycle request.  The sequencer takes it only
// at a rising edge where it is idle or finishing (IDLE/DONE) and cancel is
// low.  stall tells the requester to hold its instruction in EXE until the
// operation has finished.  done pulses for one cycle when hi/lo have just
// been written.  start seen while busy is dropped, not queued.
//
// Signals (master = EXE side, slave = sequencer):
//   start  : request, one cycle
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   ea, eb : rs/rt operands
//   cancel : synchronous abort of the operation in flight
//   busy   : operation in flight
//   stall  : freeze IF/ID/EXE
//   done   : one-cycle pulse, hi/lo just updated
//   hi, lo : HI/LO architectural registers
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic             cancel;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, ea, eb, cancel,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, ea, eb, cancel,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer owning HI/LO.
//
// A shift-add multiply or restoring divide runs on operand magnitudes for
// WIDTH iterations; signs are reapplied in a single fix-up cycle.
// Flow: IDLE/DONE --start--> PREP --> RUN (WIDTH cycles) --> FIX --> DONE.
//
// Ports:
//   clk       : clock, rising edge
//   clrn      : synchronous active-low reset
//   bus       : muldiv_seq_if slave (start/op/ea/eb/cancel in,
//               busy/stall/done/hi/lo out)
//   dbg_state : current FSM state
//
// Optional feature macro: MULDIV_FAST_MUL_EN.  When defined, MULT/MULTU
// go straight from acceptance to FIX and use a native product, so hi/lo
// are written one edge after acceptance.  Divides are unaffected.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          clrn,
  muldiv_seq_if.slave   bus,
  output logic [2:0]    dbg_state
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     ea_q, ea_d;
  logic [WIDTH-1:0]     eb_q, eb_d;
  // x: multiplicand or divisor magnitude; y: multiplier or dividend
  // magnitude, consumed one bit per RUN iteration.
  logic [WIDTH-1:0]     x_q, x_d;
  logic [WIDTH-1:0]     y_q, y_d;
  // Multiply: running product.  Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 idle_like;
  logic                 accept;
  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0]   fast_prod;
`endif

  // Datapath terms, evaluated every cycle and consumed by the FSM below.
  always_comb begin
    idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    accept    = idle_like && bus.start && !bus.cancel;

    is_signed = ~op_q[0];
    a_neg     = is_signed & ea_q[WIDTH-1];
    b_neg     = is_signed & eb_q[WIDTH-1];
    mag_a     = a_neg ? (~ea_q + 1'b1) : ea_q;
    mag_b     = b_neg ? (~eb_q + 1'b1) : eb_q;

    // Shift-add: the carry out of the add becomes the new top bit.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                {1'b0, (y_q[0] ? x_q : {WIDTH{1'b0}})};

    // Restoring divide: remainder < divisor, so the shifted value needs
    // one extra bit, and a successful trial always fits back in WIDTH.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], y_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, x_q});
    div_diff  = div_shift[WIDTH-1:0] - x_q;

    prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix   = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                          : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    // Extending both operands to 2*WIDTH (sign or zero) makes the low
    // 2*WIDTH bits of a plain product correct for either signedness.
    if (op_q[0]) begin
      fast_prod = {{WIDTH{1'b0}}, ea_q} * {{WIDTH{1'b0}}, eb_q};
    end else begin
      fast_prod = {{WIDTH{ea_q[WIDTH-1]}}, ea_q} *
                  {{WIDTH{eb_q[WIDTH-1]}}, eb_q};
    end
`endif
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ea_d      = ea_q;
    eb_d      = eb_q;
    x_d       = x_q;
    y_d       = y_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = bus.op;
          ea_d    = bus.ea;
          eb_d    = bus.eb;
          busy_d  = 1'b1;
          state_d = S_PREP;
`ifdef MULDIV_FAST_MUL_EN
          if (!bus.op[1]) begin
            state_d = S_FIX;
          end
`endif
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      S_PREP: begin
        if (op_q[1]) begin
          x_d = mag_b;
          y_d = mag_a;
        end else begin
          x_d = mag_a;
          y_d = mag_b;
        end
        neg_res_d = a_neg ^ b_neg;
        neg_rem_d = a_neg;
        acc_d     = '0;
        cnt_d     = '0;
        state_d   = S_RUN;
      end

      S_RUN: begin
        if (op_q[1]) begin
          acc_d[2*WIDTH-1:WIDTH] = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_d[WIDTH-1:0]       = {acc_q[WIDTH-2:0], div_ge};
          y_d                    = {y_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          y_d   = {1'b0, y_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (op_q[1]) begin
          if (eb_q == '0) begin
            lo_d = '1;
            hi_d = ea_q;
          end else begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          {hi_d, lo_d} = fast_prod;
`else
          {hi_d, lo_d} = prod_fix;
`endif
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything the operation was about to do.
    if (bus.cancel && !idle_like) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      ea_q      <= '0;
      eb_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ea_q      <= ea_d;
      eb_q      <= eb_d;
      x_q       <= x_d;
      y_q       <= y_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  // A request arriving while idle stalls immediately so the instruction
  // stays in EXE for the cycle in which it is accepted.
  assign bus.stall = busy_q | (bus.start & idle_like);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2*W-1:0] exp;   // {hi, lo}
  } vec_t;

  logic       clk;
  logic       clrn;
  logic [2:0] dbg_state;

  muldiv_seq_if #(.WIDTH(W)) bus ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [2*W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (clrn === 1'b1 && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 hi=0x%0h lo=0x%0h required no done",
                 bus.hi, bus.lo);
      end else begin
        check("result_hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] model(input logic [1:0] o,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = ua * ub;
      default: begin
        if (b == '0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  function automatic int lat_of(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    if (!o[1]) return 1;
`endif
    return W + 2;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at the negedge after the accepting edge; returns at the negedge
  // where done is seen (or when the bound expires).
  task automatic wait_done(output int edges, output bit stall_ok);
    edges    = 0;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 200) begin
      if (bus.stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp);
    int edges;
    bit stall_ok;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.ea    = a;
    bus.eb    = b;
    exp_q.push_back(exp);
    #1;
    check("stall_on_request", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, stall_ok);
    check("latency", 64'(edges), 64'(lat_of(o)));
    check("stall_held", {63'd0, stall_ok}, 64'd1);
    check("stall_low_in_done", {63'd0, bus.stall}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  // Start DIVU 9/2 and return at the negedge where the RUN counter is 10.
  task automatic start_div_to_cnt10();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.ea    = 32'd9;
    bus.eb    = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[10];

  initial begin
    int edges;
    bit stall_ok;
    logic [1:0]   o;
    logic [W-1:0] a, b;

    vecs[0] = '{2'b00, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
    vecs[1] = '{2'b11, 32'd100,       32'd7,         {32'd2, 32'd14}};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{2'b10, 32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[5] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[6] = '{2'b11, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF};
    vecs[7] = '{2'b10, 32'hFFFF_FFF8, 32'd0,         64'hFFFF_FFF8_FFFF_FFFF};
    vecs[8] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[9] = '{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};

    clrn       = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.ea     = '0;
    bus.eb     = '0;
    bus.cancel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;

    // Reset state
    check("reset_hi",    {32'd0, bus.hi}, 64'd0);
    check("reset_lo",    {32'd0, bus.lo}, 64'd0);
    check("reset_busy",  {63'd0, bus.busy}, 64'd0);
    check("reset_done",  {63'd0, bus.done}, 64'd0);
    check("reset_stall", {63'd0, bus.stall}, 64'd0);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Back-to-back: start held high from the first accept through DONE.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.ea    = 32'hFFFF_FFFD;
    bus.eb    = 32'd7;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk);
    @(negedge clk);
    // Junk operands while the first op runs; start stays high and is ignored.
    bus.op = 2'b10;
    bus.ea = 32'hDEAD_BEEF;
    bus.eb = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.op = 2'b11;
    bus.ea = 32'd100;
    bus.eb = 32'd7;
    exp_q.push_back({32'd2, 32'd14});
    edges = 0;
    stall_ok = 1'b1;
    while (bus.done !== 1'b1 && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check("b2b_first_latency", 64'(edges + 1), 64'(lat_of(2'b00)));
    check("b2b_stall_in_done", {63'd0, bus.stall}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_no_idle_gap", {63'd0, bus.busy}, 64'd1);
    wait_done(edges, stall_ok);
    check("b2b_second_latency", 64'(edges), 64'(lat_of(2'b11)));

    // Start pulses during RUN are ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.ea    = 32'd1000;
    bus.eb    = 32'd3;
    exp_q.push_back(64'd3000);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b11;
    bus.ea    = 32'd77;
    bus.eb    = 32'd5;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(edges, stall_ok);
    check("run_pulse_latency", 64'(edges + 6), 64'(lat_of(2'b01)));
    repeat (3) @(negedge clk);

    // Abort with cancel at RUN cnt=10.
    run_op(2'b01, 32'd5, 32'd6, 64'd30);
    start_div_to_cnt10();
    bus.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy",  {63'd0, bus.busy}, 64'd0);
    check("cancel_stall", {63'd0, bus.stall}, 64'd0);
    check("cancel_hi_lo", {bus.hi, bus.lo}, 64'd30);
    repeat (40) @(negedge clk);
    check("cancel_hi_lo_later", {bus.hi, bus.lo}, 64'd30);

    // Cancel together with start in IDLE: not accepted.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = 2'b01;
    bus.ea     = 32'd2;
    bus.eb     = 32'd2;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_start_idle_busy", {63'd0, bus.busy}, 64'd0);
    repeat (40) @(negedge clk);

    // Reset mid-RUN discards the operation and clears HI/LO.
    run_op(2'b01, 32'd5, 32'd6, 64'd30);
    start_div_to_cnt10();
    clrn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b1;
    check("rst_mid_hi_lo", {bus.hi, bus.lo}, 64'd0);
    check("rst_mid_busy",  {63'd0, bus.busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_mid_hi_lo_later", {bus.hi, bus.lo}, 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 48; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h8000_0000;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(o, a, b, model(o, a, b));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
